// File: rtl/beam_delay_scheduler_pkg.sv
// Shared constants and state encoding for the delay-and-sum beamformer sequencer.
// NUMBER_OF_BITS and BUFFER_SIZE must match the channel buffers this block reads from.
package beam_delay_scheduler_pkg;

   localparam int NUMBER_OF_BITS = 8;
   localparam int BUFFER_SIZE    = 8;
   localparam int IDX_W          = $clog2(BUFFER_SIZE) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_e;

   // The delay registers are one bit wider than a buffer index.
   // Any value past the last buffer slot is pulled back to the oldest sample.
   function automatic logic [IDX_W-1:0] clampIndex(input logic [IDX_W-1:0] idx);
      if (idx > IDX_W'(BUFFER_SIZE - 1)) begin
         return IDX_W'(BUFFER_SIZE - 1);
      end
      return idx;
   endfunction

endpackage

// File: rtl/delay_config_regs.sv
// Steering delay register file for the beamformer.
// Each channel has a shadow register, loaded serially from the config port, and an
// active register. The active register is used by the frame that is currently running.
module delay_config_regs
   import beam_delay_scheduler_pkg::*;
#(
   parameter int NUM_CHANNELS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_strobe_i,
   input  logic [2:0]       cfg_sel_i,
   input  logic             cfg_data_i,
   input  logic             commit_i,
   input  logic [2:0]       lookup_ch_i,
   output logic [IDX_W-1:0] lookup_idx_o
);

   logic [IDX_W-1:0] shadow_q [NUM_CHANNELS];
   logic [IDX_W-1:0] shadow_d [NUM_CHANNELS];
   logic [IDX_W-1:0] active_q [NUM_CHANNELS];
   logic [IDX_W-1:0] active_d [NUM_CHANNELS];
   logic [IDX_W-1:0] selected;

   // The serial shift only updates the shadow copy. The commit copies the shadow
   // values that exist before this edge, so a shift on the same edge waits for the next frame.
   // A cfg_sel value with no matching channel updates nothing.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (cfg_strobe_i && (cfg_sel_i == 3'(i))) begin
            shadow_d[i] = {shadow_q[i][IDX_W-2:0], cfg_data_i};
         end
         if (commit_i) begin
            active_d[i] = shadow_q[i];
         end
      end
   end

   // This block is the register file state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   // This block finds the clamped index for the channel that is read next.
   // During a commit the active copy is not updated yet, so the block reads the shadow value instead.
   always_comb begin
      selected = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (lookup_ch_i == 3'(i)) begin
            selected = commit_i ? shadow_q[i] : active_q[i];
         end
      end
      lookup_idx_o = clampIndex(selected);
   end

endmodule

// File: rtl/beam_delay_scheduler.sv
// Frame sequencer for the delay-and-sum beamformer.
// For each accepted frame the block reads every channel buffer once at its steering delay.
// It adds the samples as signed values and outputs one beam sum.
module beam_delay_scheduler
   import beam_delay_scheduler_pkg::*;
#(
   parameter int NUM_CHANNELS = 2,
   localparam int SUM_W       = NUMBER_OF_BITS + $clog2(NUM_CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sample_valid,
   input  logic                      cfg_strobe,
   input  logic [2:0]                cfg_sel,
   input  logic                      cfg_data,
   output logic [2:0]                rd_channel,
   output logic [IDX_W-1:0]          rd_index,
   input  logic [NUMBER_OF_BITS-1:0] rd_data,
   output logic [SUM_W-1:0]          sum_out,
   output logic                      sum_valid,
   output logic                      busy,
   output logic                      overrun,
   input  logic                      overrun_clr
);

   localparam logic [2:0] LAST_CH = 3'(NUM_CHANNELS - 1);

   state_e                  state_q, state_d;
   logic [2:0]              ch_q, ch_d;
   logic signed [SUM_W-1:0] acc_q, acc_d;
   logic [2:0]              rdChannel_q, rdChannel_d;
   logic [IDX_W-1:0]        rdIndex_q, rdIndex_d;
   logic [SUM_W-1:0]        sumOut_q, sumOut_d;
   logic                    sumValid_q, sumValid_d;
   logic                    overrun_q, overrun_d;
   logic                    commit;
   logic [2:0]              lookupCh;
   logic [IDX_W-1:0]        lookupIdx;
   logic signed [SUM_W-1:0] sampleExt;

   delay_config_regs #(
      .NUM_CHANNELS(NUM_CHANNELS)
   ) u_delay_config_regs (
      .clk          (clk),
      .reset        (reset),
      .cfg_strobe_i (cfg_strobe),
      .cfg_sel_i    (cfg_sel),
      .cfg_data_i   (cfg_data),
      .commit_i     (commit),
      .lookup_ch_i  (lookupCh),
      .lookup_idx_o (lookupIdx)
   );

   assign sampleExt = SUM_W'($signed(rd_data));

   // This block is the next-state logic for the frame sequencer.
   // The read port is set up one edge early, so each channel has its whole READ cycle.
   // The last add goes directly into sum_out, so sum_valid is high during DONE.
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      acc_d       = acc_q;
      rdChannel_d = rdChannel_q;
      rdIndex_d   = rdIndex_q;
      sumOut_d    = sumOut_q;
      sumValid_d  = 1'b0;
      commit      = 1'b0;
      lookupCh    = 3'd0;
      unique case (state_q)
         IDLE: begin
            if (sample_valid) begin
               state_d     = READ;
               commit      = 1'b1;
               acc_d       = '0;
               ch_d        = 3'd0;
               lookupCh    = 3'd0;
               rdChannel_d = 3'd0;
               rdIndex_d   = lookupIdx;
            end
         end
         READ: begin
            acc_d = acc_q + sampleExt;
            if (ch_q == LAST_CH) begin
               state_d    = DONE;
               sumOut_d   = acc_q + sampleExt;
               sumValid_d = 1'b1;
            end else begin
               ch_d        = ch_q + 3'd1;
               lookupCh    = ch_q + 3'd1;
               rdChannel_d = ch_q + 3'd1;
               rdIndex_d   = lookupIdx;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The overrun flag is sticky. A frame that arrives during READ or DONE is dropped and sets the flag.
   // When a set and a clear happen in the same cycle, the set takes priority.
   always_comb begin
      overrun_d = overrun_q;
      if (sample_valid && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end
   end

   // This block is the state register for the sequencer, the accumulator and the registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ch_q        <= 3'd0;
         acc_q       <= '0;
         rdChannel_q <= 3'd0;
         rdIndex_q   <= '0;
         sumOut_q    <= '0;
         sumValid_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         acc_q       <= acc_d;
         rdChannel_q <= rdChannel_d;
         rdIndex_q   <= rdIndex_d;
         sumOut_q    <= sumOut_d;
         sumValid_q  <= sumValid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rd_channel = rdChannel_q;
   assign rd_index   = rdIndex_q;
   assign sum_out    = sumOut_q;
   assign sum_valid  = sumValid_q;
   assign busy       = (state_q != IDLE);
   assign overrun    = overrun_q;

endmodule
